local_bias_ctrl: RTL and testbench
==================================

LOCAL_BIAS_CTRL -- requirements
Module: local_bias_ctrl

Interface
- REQ-001 Parameter SETTLE_CYC, default 16: cycles pdb is held high before ready asserts.
- REQ-002 Parameter DWELL_CYC, default 8: cycles one testbus selection is driven on atb_ena.
- REQ-003 Parameter FILT_CYC, default 4: consecutive out-of-window samples that declare a supply fault.
- REQ-004 Parameter RETRY_CYC, default 32: cycles spent in FAULT before automatic retry.
- REQ-005 Port clk, input, 1: single clock; every state update occurs on its rising edge.
- REQ-006 Port rstn, input, 1: synchronous, active-low reset.
- REQ-007 Port en, input, 1: bias enable request from the system.
- REQ-008 Port vddana_1p8, input, real: 1.8 V supply, sampled on each clk edge.
- REQ-009 Port vddana_0p8, input, real: 0.8 V supply, sampled on each clk edge.
- REQ-010 Port vssana, input, real: analog ground, sampled on each clk edge.
- REQ-011 Port atb_req, input, 1: testbus access request.
- REQ-012 Port atb_sel, input, 2: requested testbus selection; must be held stable while atb_req is high.
- REQ-013 Port pdb, output, 1: power-down-bar to the local bias block.
- REQ-014 Port atb_ena, output, [0:1]: testbus enable to the local bias block.
- REQ-015 Port ready, output, 1: bias currents valid.
- REQ-016 Port atb_ack, output, 1: one-cycle pulse marking completion of a testbus access.
- REQ-017 Port fault, output, 1: high while in FAULT.
- REQ-018 Port state, output, 3: current FSM state, for debug.

Function
- REQ-019 The supply is OK when vddana_1p8 is in [1.71, 1.89], vddana_0p8 is in [0.76, 0.84] and vssana is in [-0.05, 0.05], all bounds inclusive.
- REQ-020 A saturating filter counter shall count consecutive not-OK samples and clear on any OK sample; sup_bad asserts when the count reaches FILT_CYC.
- REQ-021 FSM states: OFF, WAIT_SUP, SETTLE, READY, ATB, FAULT.
- REQ-022 OFF -> WAIT_SUP when en=1.
- REQ-023 WAIT_SUP -> SETTLE on the first cycle the supply is OK.
- REQ-024 SETTLE: pdb=1 and a counter runs; -> READY after exactly SETTLE_CYC cycles in SETTLE.
- REQ-025 READY: pdb=1 and ready=1; -> ATB when atb_req=1 and atb_sel!=2'b00, capturing atb_sel into an internal register.
- REQ-026 A READY request with atb_sel=2'b00 shall be completed in place: one atb_ack pulse, no state change.
- REQ-027 ATB: atb_ena shall equal the captured selection for DWELL_CYC cycles, then atb_ack=1 for one cycle and the FSM returns to READY with atb_ena=2'b00 on that same cycle.
- REQ-028 After an atb_ack, a new request is accepted only once atb_req has been sampled low at least once (edge-armed).
- REQ-029 A changing atb_sel during ATB shall have no effect.
- REQ-030 In any state, en=0 -> OFF on the next edge, which has priority over every other transition.
- REQ-031 In SETTLE, READY or ATB, sup_bad -> FAULT; sup_bad has priority over request acceptance.
- REQ-032 FAULT: pdb=0 and fault=1; after RETRY_CYC cycles -> WAIT_SUP if en=1.
- REQ-033 On exit from ATB through en=0 or a fault, atb_ena shall be 2'b00 and no atb_ack shall be issued.
- REQ-034 In OFF, WAIT_SUP and FAULT, pdb=0, ready=0 and atb_ena=2'b00.
- REQ-035 All outputs shall be registered; every counter shall be wide enough for its parameter and shall saturate rather than wrap.

Reset
- REQ-036 While rstn=0 at a clk edge, the FSM shall enter OFF, all counters and the captured selection shall clear, and the request arm bit shall be set.
- REQ-037 Reset values: pdb=0, atb_ena=2'b00, ready=0, atb_ack=0, fault=0, state=OFF.
- REQ-038 Reset taken mid-SETTLE or mid-ATB shall abort with no atb_ack.

Structure
- REQ-039 The state enum, the 3-bit encoding and the supply window constants shall live in a shared package, local_bias_ctrl_pkg.
- REQ-040 The window compare and glitch filter shall be one sub-module, supply_mon, which outputs sup_bad.

Verification
- REQ-041 Nominal supplies, en rises at t0 -> pdb=1 at t0+2, ready=1 at t0+2+16 cycles.
- REQ-042 In READY, atb_req with atb_sel=2'b11 -> atb_ena=2'b11 for 8 cycles, one atb_ack pulse, then atb_ena=2'b00; atb_req held high -> no second access.
- REQ-043 vddana_0p8=0.70 for 3 cycles -> no fault; for 4 cycles -> fault=1 and pdb=0; supply restored -> WAIT_SUP after 32 cycles, then re-settle.
- REQ-044 en=0 during cycle 4 of ATB -> OFF next edge, atb_ena=2'b00, no atb_ack.
- REQ-045 rstn=0 mid-SETTLE -> all outputs at reset values on the next edge; release with en=1 -> full 16-cycle settle again.
- REQ-046 vssana=0.05 exactly -> OK; vssana=0.051 held for 4 cycles -> fault.

Source files
------------

// File: rtl/local_bias_ctrl_pkg.sv
// Shared definitions for the local bias controller: FSM state encoding,
// supply window limits and small helpers used by the controller and monitor.
package local_bias_ctrl_pkg;

   // Controller states with their fixed 3-bit debug encoding
   typedef enum logic [2:0] {
      ST_OFF      = 3'd0,
      ST_WAIT_SUP = 3'd1,
      ST_SETTLE   = 3'd2,
      ST_READY    = 3'd3,
      ST_ATB      = 3'd4,
      ST_FAULT    = 3'd5
   } bias_state_e;

   localparam int unsigned STATE_W = 3;

   // Supply acceptance windows in volts, bounds inclusive
   localparam real VDD18_MIN = 1.71;
   localparam real VDD18_MAX = 1.89;
   localparam real VDD08_MIN = 0.76;
   localparam real VDD08_MAX = 0.84;
   localparam real VSS_MIN   = -0.05;
   localparam real VSS_MAX   = 0.05;

   // Testbus selection that is acknowledged without entering ATB
   localparam logic [1:0] ATB_SEL_NONE = 2'b00;

   // Inclusive window test on a sampled analog level
   function automatic logic in_window(input real v, input real lo, input real hi);
      return (v >= lo) && (v <= hi);
   endfunction

   // Largest of three timer limits, used to size a shared timer
   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/local_bias_ctrl_supply_mon.sv
// Supply window comparator with a consecutive-bad-sample glitch filter.
// sup_ok reflects the current sample; sup_bad asserts once FILT_CYC
// consecutive out-of-window samples have been seen, including this one.
module supply_mon
   import local_bias_ctrl_pkg::*;
#(
   parameter int unsigned FILT_CYC = 4
) (
   input  logic clk,
   input  logic rstn,
   input  real  vddana_1p8,
   input  real  vddana_0p8,
   input  real  vssana,
   output logic sup_ok,
   output logic sup_bad
);

   localparam int unsigned CW = $clog2(FILT_CYC + 1);
   localparam logic [CW-1:0] FILT_LIMIT = CW'(FILT_CYC);

   logic [CW-1:0] bad_cnt_q;
   logic [CW-1:0] bad_cnt_d;

   // Window compare and saturating count of consecutive bad samples
   always_comb begin
      sup_ok = in_window(vddana_1p8, VDD18_MIN, VDD18_MAX) &&
               in_window(vddana_0p8, VDD08_MIN, VDD08_MAX) &&
               in_window(vssana, VSS_MIN, VSS_MAX);
      bad_cnt_d = bad_cnt_q;
      if (sup_ok) begin
         bad_cnt_d = '0;
      end else if (bad_cnt_q != FILT_LIMIT) begin
         bad_cnt_d = bad_cnt_q + CW'(1);
      end
      sup_bad = (bad_cnt_d == FILT_LIMIT);
   end

   // Filter counter register with synchronous active-low clear
   always_ff @(posedge clk) begin
      if (!rstn) begin
         bad_cnt_q <= '0;
      end else begin
         bad_cnt_q <= bad_cnt_d;
      end
   end

endmodule

// File: rtl/local_bias_ctrl.sv
// Local bias controller: sequences power-up of the bias block, arbitrates
// testbus accesses and drops into a timed FAULT state on supply loss.
// Every output is a flop loaded from the decoded next state.
module local_bias_ctrl
   import local_bias_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE_CYC = 16,
   parameter int unsigned DWELL_CYC  = 8,
   parameter int unsigned FILT_CYC   = 4,
   parameter int unsigned RETRY_CYC  = 32
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               en,
   input  real                vddana_1p8,
   input  real                vddana_0p8,
   input  real                vssana,
   input  logic               atb_req,
   input  logic [1:0]         atb_sel,
   output logic               pdb,
   output logic [0:1]         atb_ena,
   output logic               ready,
   output logic               atb_ack,
   output logic               fault,
   output logic [STATE_W-1:0] state
);

   // One timer is shared by SETTLE, ATB and FAULT; it restarts on every state change
   localparam int unsigned TMAX = max3(SETTLE_CYC, DWELL_CYC, RETRY_CYC);
   localparam int unsigned TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] TMR_SAT     = TW'(TMAX);
   localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
   localparam logic [TW-1:0] DWELL_LAST  = TW'(DWELL_CYC - 1);
   localparam logic [TW-1:0] RETRY_LAST  = TW'(RETRY_CYC - 1);

   logic sup_ok;
   logic sup_bad;

   bias_state_e   state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [TW-1:0] tmr_inc;
   logic [1:0]    sel_q, sel_d;
   logic          arm_q, arm_d;
   logic          pdb_q, pdb_d;
   logic          ready_q, ready_d;
   logic          fault_q, fault_d;
   logic          ack_q, ack_d;
   logic [1:0]    atb_ena_q, atb_ena_d;

   supply_mon #(
      .FILT_CYC (FILT_CYC)
   ) u_supply_mon (
      .clk        (clk),
      .rstn       (rstn),
      .vddana_1p8 (vddana_1p8),
      .vddana_0p8 (vddana_0p8),
      .vssana     (vssana),
      .sup_ok     (sup_ok),
      .sup_bad    (sup_bad)
   );

   // Next-state, timer, capture and request-arm logic
   always_comb begin
      state_d = state_q;
      tmr_inc = (tmr_q == TMR_SAT) ? tmr_q : tmr_q + TW'(1);
      tmr_d   = tmr_q;
      sel_d   = sel_q;
      arm_d   = atb_req ? arm_q : 1'b1;
      ack_d   = 1'b0;

      if (!en) begin
         state_d = ST_OFF;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d = ST_WAIT_SUP;
            end
            ST_WAIT_SUP: begin
               if (sup_ok) begin
                  state_d = ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (sup_bad) begin
                  state_d = ST_FAULT;
               end else if (tmr_q >= SETTLE_LAST) begin
                  state_d = ST_READY;
               end else begin
                  tmr_d = tmr_inc;
               end
            end
            ST_READY: begin
               if (sup_bad) begin
                  state_d = ST_FAULT;
               end else if (atb_req && arm_q) begin
                  if (atb_sel != ATB_SEL_NONE) begin
                     state_d = ST_ATB;
                     sel_d   = atb_sel;
                  end else begin
                     ack_d = 1'b1;
                     arm_d = 1'b0;
                  end
               end
            end
            ST_ATB: begin
               if (sup_bad) begin
                  state_d = ST_FAULT;
               end else if (tmr_q >= DWELL_LAST) begin
                  state_d = ST_READY;
                  ack_d   = 1'b1;
                  arm_d   = 1'b0;
               end else begin
                  tmr_d = tmr_inc;
               end
            end
            ST_FAULT: begin
               if (tmr_q >= RETRY_LAST) begin
                  state_d = ST_WAIT_SUP;
               end else begin
                  tmr_d = tmr_inc;
               end
            end
            default: begin
               state_d = ST_OFF;
            end
         endcase
      end

      if (state_d != state_q) begin
         tmr_d = '0;
      end
   end

   // Output decode from the next state so every output leaves a flop
   always_comb begin
      pdb_d     = (state_d == ST_SETTLE) || (state_d == ST_READY) || (state_d == ST_ATB);
      ready_d   = (state_d == ST_READY);
      fault_d   = (state_d == ST_FAULT);
      atb_ena_d = (state_d == ST_ATB) ? sel_d : ATB_SEL_NONE;
   end

   // FSM and registered outputs with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q   <= ST_OFF;
         tmr_q     <= '0;
         sel_q     <= '0;
         arm_q     <= 1'b1;
         pdb_q     <= 1'b0;
         ready_q   <= 1'b0;
         fault_q   <= 1'b0;
         ack_q     <= 1'b0;
         atb_ena_q <= ATB_SEL_NONE;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         sel_q     <= sel_d;
         arm_q     <= arm_d;
         pdb_q     <= pdb_d;
         ready_q   <= ready_d;
         fault_q   <= fault_d;
         ack_q     <= ack_d;
         atb_ena_q <= atb_ena_d;
      end
   end

   assign pdb     = pdb_q;
   assign ready   = ready_q;
   assign fault   = fault_q;
   assign atb_ack = ack_q;
   assign atb_ena = atb_ena_q;
   assign state   = state_q;

endmodule

// File: tb/tb_local_bias_ctrl.sv
// Testbench for local_bias_ctrl: directed scenarios plus randomized testbus
// traffic and supply glitches, with expectations derived from cycle counts.
module tb_local_bias_ctrl;
   import local_bias_ctrl_pkg::*;

   localparam int SETTLE = 16;
   localparam int DWELL  = 8;
   localparam int FILT   = 4;
   localparam int RETRY  = 32;

   logic       clk = 1'b0;
   logic       rstn;
   logic       en;
   logic       atb_req;
   logic [1:0] atb_sel;
   real        v18, v08, vss;
   logic       pdb, ready, atb_ack, fault;
   logic [0:1] atb_ena;
   logic [2:0] state;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   local_bias_ctrl #(
      .SETTLE_CYC (SETTLE),
      .DWELL_CYC  (DWELL),
      .FILT_CYC   (FILT),
      .RETRY_CYC  (RETRY)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .en         (en),
      .vddana_1p8 (v18),
      .vddana_0p8 (v08),
      .vssana     (vss),
      .atb_req    (atb_req),
      .atb_sel    (atb_sel),
      .pdb        (pdb),
      .atb_ena    (atb_ena),
      .ready      (ready),
      .atb_ack    (atb_ack),
      .fault      (fault),
      .state      (state)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs changed afterwards are seen at the next edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic nominal();
      v18 = 1.8;
      v08 = 0.8;
      vss = 0.0;
   endtask

   task automatic go_off();
      en = 1'b0;
      atb_req = 1'b0;
      atb_sel = 2'b00;
      nominal();
      ticks(2);
   endtask

   task automatic go_ready();
      en = 1'b1;
      for (int i = 0; i < 80 && ready !== 1'b1; i++) tick();
      n_cmp++;
      if (ready !== 1'b1) begin n_err++; $display("[TB] FAIL go_ready_timeout: ready=%b required 1", ready); end
   endtask

   task automatic test_reset();
      rstn = 1'b0; en = 1'b0; atb_req = 1'b0; atb_sel = 2'b00; nominal();
      ticks(2);
      n_cmp++; if (pdb !== 1'b0) begin n_err++; $display("[TB] FAIL reset_pdb: got %b required 0", pdb); end
      n_cmp++; if (atb_ena !== 2'b00) begin n_err++; $display("[TB] FAIL reset_atb_ena: got %b required 00", atb_ena); end
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ready: got %b required 0", ready); end
      n_cmp++; if (atb_ack !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ack: got %b required 0", atb_ack); end
      n_cmp++; if (fault !== 1'b0) begin n_err++; $display("[TB] FAIL reset_fault: got %b required 0", fault); end
      n_cmp++; if (state !== ST_OFF) begin n_err++; $display("[TB] FAIL reset_state: got %0d required %0d", state, ST_OFF); end
      rstn = 1'b1;
      tick();
      n_cmp++; if (state !== ST_OFF) begin n_err++; $display("[TB] FAIL idle_state: got %0d required %0d", state, ST_OFF); end
   endtask

   // en rises right after an edge: pdb two edges later, ready SETTLE edges after that
   task automatic test_powerup();
      logic [2:0] exp_state;
      en = 1'b1;
      for (int k = 1; k <= 2 + SETTLE; k++) begin
         tick();
         exp_state = (k == 1) ? ST_WAIT_SUP : ((k < 2 + SETTLE) ? ST_SETTLE : ST_READY);
         n_cmp++; if (state !== exp_state) begin n_err++; $display("[TB] FAIL powerup_state k=%0d: got %0d required %0d", k, state, exp_state); end
         n_cmp++; if (pdb !== (k >= 2)) begin n_err++; $display("[TB] FAIL powerup_pdb k=%0d: got %b required %b", k, pdb, k >= 2); end
         n_cmp++; if (ready !== (k >= 2 + SETTLE)) begin n_err++; $display("[TB] FAIL powerup_ready k=%0d: got %b required %b", k, ready, k >= 2 + SETTLE); end
      end
   endtask

   task automatic test_atb();
      logic [1:0] exp_ena;
      atb_sel = 2'b11; atb_req = 1'b1;
      for (int k = 1; k <= DWELL + 6; k++) begin
         tick();
         exp_ena = (k <= DWELL) ? 2'b11 : 2'b00;
         n_cmp++; if (atb_ena !== exp_ena) begin n_err++; $display("[TB] FAIL atb_ena k=%0d: got %b required %b", k, atb_ena, exp_ena); end
         n_cmp++; if (atb_ack !== (k == DWELL + 1)) begin n_err++; $display("[TB] FAIL atb_ack k=%0d: got %b required %b", k, atb_ack, k == DWELL + 1); end
      end
      n_cmp++; if (state !== ST_READY) begin n_err++; $display("[TB] FAIL atb_return_state: got %0d required %0d", state, ST_READY); end
      atb_req = 1'b0; tick();
      atb_sel = 2'b00; atb_req = 1'b1; tick();
      n_cmp++; if (atb_ack !== 1'b1) begin n_err++; $display("[TB] FAIL inplace_ack: got %b required 1", atb_ack); end
      n_cmp++; if (state !== ST_READY) begin n_err++; $display("[TB] FAIL inplace_state: got %0d required %0d", state, ST_READY); end
      tick();
      n_cmp++; if (atb_ack !== 1'b0) begin n_err++; $display("[TB] FAIL inplace_single_pulse: got %b required 0", atb_ack); end
      atb_req = 1'b0; tick();
   endtask

   task automatic test_filter();
      v08 = 0.70;
      for (int k = 1; k <= FILT - 1; k++) begin
         tick();
         n_cmp++; if (fault !== 1'b0) begin n_err++; $display("[TB] FAIL short_glitch_fault k=%0d: got %b required 0", k, fault); end
      end
      v08 = 0.8;
      ticks(2);
      n_cmp++; if (pdb !== 1'b1) begin n_err++; $display("[TB] FAIL short_glitch_pdb: got %b required 1", pdb); end
      v08 = 0.70;
      for (int k = 1; k <= FILT; k++) begin
         tick();
         n_cmp++; if (fault !== (k == FILT)) begin n_err++; $display("[TB] FAIL long_glitch_fault k=%0d: got %b required %b", k, fault, k == FILT); end
      end
      n_cmp++; if (pdb !== 1'b0) begin n_err++; $display("[TB] FAIL fault_pdb: got %b required 0", pdb); end
      n_cmp++; if (ready !== 1'b0) begin n_err++; $display("[TB] FAIL fault_ready: got %b required 0", ready); end
      v08 = 0.8;
      for (int k = 1; k <= RETRY; k++) begin
         tick();
         n_cmp++; if (state !== ((k < RETRY) ? ST_FAULT : ST_WAIT_SUP)) begin n_err++; $display("[TB] FAIL retry_state k=%0d: got %0d", k, state); end
      end
      for (int k = 1; k <= SETTLE + 1; k++) begin
         tick();
         n_cmp++; if (ready !== (k == SETTLE + 1)) begin n_err++; $display("[TB] FAIL resettle_ready k=%0d: got %b required %b", k, ready, k == SETTLE + 1); end
      end
   endtask

   task automatic test_en_abort();
      atb_sel = 2'b10; atb_req = 1'b1;
      ticks(4);
      n_cmp++; if (atb_ena !== 2'b10) begin n_err++; $display("[TB] FAIL abort_pre_ena: got %b required 10", atb_ena); end
      en = 1'b0; tick();
      n_cmp++; if (state !== ST_OFF) begin n_err++; $display("[TB] FAIL abort_state: got %0d required %0d", state, ST_OFF); end
      n_cmp++; if (atb_ena !== 2'b00) begin n_err++; $display("[TB] FAIL abort_ena: got %b required 00", atb_ena); end
      atb_req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if (atb_ack !== 1'b0) begin n_err++; $display("[TB] FAIL abort_no_ack k=%0d: got %b required 0", k, atb_ack); end
         tick();
      end
      go_ready();
   endtask

   task automatic test_reset_mid();
      go_off();
      en = 1'b1; ticks(7);
      n_cmp++; if (pdb !== 1'b1) begin n_err++; $display("[TB] FAIL midsettle_pdb: got %b required 1", pdb); end
      rstn = 1'b0; tick();
      n_cmp++; if ({pdb, ready, atb_ack, fault, atb_ena} !== 6'b0) begin n_err++; $display("[TB] FAIL midsettle_reset_outs: got %b required 000000", {pdb, ready, atb_ack, fault, atb_ena}); end
      n_cmp++; if (state !== ST_OFF) begin n_err++; $display("[TB] FAIL midsettle_reset_state: got %0d required %0d", state, ST_OFF); end
      rstn = 1'b1;
      for (int k = 1; k <= 2 + SETTLE; k++) begin
         tick();
         n_cmp++; if (ready !== (k == 2 + SETTLE)) begin n_err++; $display("[TB] FAIL resettle_after_reset k=%0d: got %b required %b", k, ready, k == 2 + SETTLE); end
      end
      atb_sel = 2'b01; atb_req = 1'b1; ticks(3);
      rstn = 1'b0; en = 1'b0; tick();
      n_cmp++; if (atb_ena !== 2'b00 || atb_ack !== 1'b0) begin n_err++; $display("[TB] FAIL midatb_reset: ena=%b ack=%b required 00/0", atb_ena, atb_ack); end
      rstn = 1'b1; atb_req = 1'b0; tick();
      n_cmp++; if (atb_ack !== 1'b0) begin n_err++; $display("[TB] FAIL midatb_no_ack: got %b required 0", atb_ack); end
      go_ready();
   endtask

   task automatic test_boundary();
      vss = 0.05; v18 = 1.89; v08 = 0.76;
      for (int k = 1; k <= 8; k++) begin
         tick();
         n_cmp++; if (state !== ST_READY) begin n_err++; $display("[TB] FAIL upper_edges_ok k=%0d: state=%0d required %0d", k, state, ST_READY); end
      end
      vss = -0.05; v18 = 1.71; v08 = 0.84;
      for (int k = 1; k <= 8; k++) begin
         tick();
         n_cmp++; if (fault !== 1'b0) begin n_err++; $display("[TB] FAIL lower_edges_ok k=%0d: fault=%b required 0", k, fault); end
      end
      nominal(); vss = 0.051;
      for (int k = 1; k <= FILT; k++) begin
         tick();
         n_cmp++; if (fault !== (k == FILT)) begin n_err++; $display("[TB] FAIL vss_over k=%0d: got %b required %b", k, fault, k == FILT); end
      end
      go_off();
      go_ready();
   endtask

   task automatic bad_supply();
      case ($urandom_range(0, 2))
         0: v18 = ($urandom_range(0, 1) != 0) ? 1.60 : 1.95;
         1: v08 = ($urandom_range(0, 1) != 0) ? 0.70 : 0.90;
         default: vss = ($urandom_range(0, 1) != 0) ? 0.08 : -0.08;
      endcase
   endtask

   task automatic random_ok_supply();
      v18 = 1.71 + real'($urandom_range(5, 175)) / 1000.0;
      v08 = 0.76 + real'($urandom_range(5, 75)) / 1000.0;
      vss = -0.05 + real'($urandom_range(5, 95)) / 1000.0;
   endtask

   // Random accesses: each selection must appear for DWELL cycles, then one ack
   task automatic test_random();
      logic [1:0] sel;
      int g, h;
      for (int it = 0; it < 40; it++) begin
         random_ok_supply();
         g = $urandom_range(0, FILT - 1);
         for (int k = 0; k < g; k++) begin
            bad_supply(); tick();
            n_cmp++; if (fault !== 1'b0) begin n_err++; $display("[TB] FAIL rnd_glitch it=%0d: fault=%b required 0", it, fault); end
         end
         random_ok_supply(); tick();
         sel = 2'($urandom_range(0, 3));
         atb_sel = sel; atb_req = 1'b1;
         if (sel != 2'b00) begin
            for (int k = 1; k <= DWELL; k++) begin
               tick();
               if (k == 2) atb_sel = 2'($urandom_range(0, 3));
               n_cmp++; if (atb_ena !== sel || atb_ack !== 1'b0) begin n_err++; $display("[TB] FAIL rnd_dwell it=%0d k=%0d: ena=%b ack=%b required %b/0", it, k, atb_ena, atb_ack, sel); end
            end
         end
         tick();
         n_cmp++; if (atb_ack !== 1'b1 || atb_ena !== 2'b00 || state !== ST_READY) begin n_err++; $display("[TB] FAIL rnd_ack it=%0d: ack=%b ena=%b state=%0d required 1/00/%0d", it, atb_ack, atb_ena, state, ST_READY); end
         h = $urandom_range(0, 3);
         for (int k = 0; k < h; k++) begin
            tick();
            n_cmp++; if (atb_ack !== 1'b0 || state !== ST_READY) begin n_err++; $display("[TB] FAIL rnd_hold it=%0d: ack=%b state=%0d required 0/%0d", it, atb_ack, state, ST_READY); end
         end
         atb_req = 1'b0; atb_sel = 2'b00; tick();
      end
      sel = 2'($urandom_range(1, 3));
      atb_sel = sel; atb_req = 1'b1; ticks(2);
      nominal(); bad_supply();
      for (int k = 1; k <= FILT; k++) begin
         tick();
         n_cmp++; if (fault !== (k == FILT)) begin n_err++; $display("[TB] FAIL atb_fault k=%0d: got %b required %b", k, fault, k == FILT); end
      end
      n_cmp++; if (atb_ena !== 2'b00 || atb_ack !== 1'b0) begin n_err++; $display("[TB] FAIL atb_fault_exit: ena=%b ack=%b required 00/0", atb_ena, atb_ack); end
      nominal(); atb_req = 1'b0; tick();
      n_cmp++; if (atb_ack !== 1'b0) begin n_err++; $display("[TB] FAIL atb_fault_no_ack: got %b required 0", atb_ack); end
      go_off();
   endtask

   initial begin
      $display("[TB] local_bias_ctrl bench start");
      test_reset();
      test_powerup();
      test_atb();
      test_filter();
      test_en_abort();
      test_reset_mid();
      test_boundary();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation time limit reached, compared=%0d errors=%0d", n_cmp, n_err);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
